map_table: RTL and testbench

- 3-wide register rename table that sits between decode and the freelist, directly downstream of the freelist's FreeReg output.
- Holds the speculative architectural-to-physical mapping for 32 architectural registers, plus a ready bit per entry.
- Returns source tags with readiness and the previous destination mapping (Told) to the ROB; Told later comes back to the freelist as RetireReg.
- On branch recovery, copies the committed mapping from the architectural map table.

---
 rtl/map_table.sv | 125 ++++++++++++
 tb/tb_map_table.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/map_table.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | map_table : 3-wide rename table (32 arch -> PR-bit phys) with ready bits
// | Revision  : 1.0 - initial release
// +----------------------------------------------------------------------------
module map_table #(
  parameter int PR = 6,
  parameter int AR = 5
) (
  input  logic                           clock_i,
  input  logic                           reset_i,        // active-low, async
  input  logic [2:0]                     DispatchEN_i,
  input  logic [2:0][AR-1:0]             dest_arch_i,
  input  logic [2:0][AR-1:0]             src1_arch_i,
  input  logic [2:0][AR-1:0]             src2_arch_i,
  input  logic [2:0][PR-1:0]             FreeReg_i,
  input  logic [2:0]                     CDB_valid_i,
  input  logic [2:0][PR-1:0]             CDB_tag_i,
  input  logic                           BPRecoverEN_i,
  input  logic [(1<<AR)-1:0][PR-1:0]     arch_map_i,
  output logic [2:0][PR-1:0]             src1_preg_o,
  output logic [2:0]                     src1_ready_o,
  output logic [2:0][PR-1:0]             src2_preg_o,
  output logic [2:0]                     src2_ready_o,
  output logic [2:0][PR-1:0]             told_preg_o
);

  localparam int NMAP = 1 << AR;

  logic [NMAP-1:0][PR-1:0] map_q, map_d;
  logic [NMAP-1:0]         rdy_q, rdy_d;

  // Returns {preg, ready} for a source of a given slot; older slots bypass in.
  function automatic logic [PR:0] f_lookup(input int slot, input logic [AR-1:0] s);
    logic [PR-1:0] p;
    logic          r;
    logic          hit;
    p   = map_q[s];
    r   = rdy_q[s];
    hit = 1'b0;
    for (int j = 2; j >= 0; j--) begin
      if (j > slot && DispatchEN_i[j] && dest_arch_i[j] == s) begin
        p   = FreeReg_i[j];
        r   = 1'b0;
        hit = 1'b1;
      end
    end
    if (!hit) begin
      for (int k = 0; k < 3; k++) begin
        if (CDB_valid_i[k] && CDB_tag_i[k] == p) r = 1'b1;
      end
    end
    if (s == '0) begin
      p = '0;
      r = 1'b1;
    end
    return {p, r};
  endfunction

  always_comb begin
    logic [PR:0]   res;
    logic [PR-1:0] t;
    src1_preg_o  = '0;
    src1_ready_o = '0;
    src2_preg_o  = '0;
    src2_ready_o = '0;
    told_preg_o  = '0;
    res          = '0;
    t            = '0;
    for (int i = 0; i < 3; i++) begin
      res             = f_lookup(i, src1_arch_i[i]);
      src1_preg_o[i]  = res[PR:1];
      src1_ready_o[i] = res[0];
      res             = f_lookup(i, src2_arch_i[i]);
      src2_preg_o[i]  = res[PR:1];
      src2_ready_o[i] = res[0];

      t = map_q[dest_arch_i[i]];
      for (int j = 2; j >= 0; j--) begin
        if (j > i && DispatchEN_i[j] && dest_arch_i[j] == dest_arch_i[i]) t = FreeReg_i[j];
      end
      // A rename to x0 hands its register straight back at retire.
      if (dest_arch_i[i] == '0) t = FreeReg_i[i];
      told_preg_o[i] = t;
    end
  end

  always_comb begin
    map_d = map_q;
    rdy_d = rdy_q;
    if (BPRecoverEN_i) begin
      map_d = arch_map_i;
      rdy_d = '1;
    end else begin
      for (int e = 0; e < NMAP; e++) begin
        for (int k = 0; k < 3; k++) begin
          if (CDB_valid_i[k] && CDB_tag_i[k] == map_q[e]) rdy_d[e] = 1'b1;
        end
      end
      // Oldest first so the youngest duplicate dest lands last.
      for (int i = 2; i >= 0; i--) begin
        if (DispatchEN_i[i] && dest_arch_i[i] != '0) begin
          map_d[dest_arch_i[i]] = FreeReg_i[i];
          rdy_d[dest_arch_i[i]] = 1'b0;
        end
      end
    end
    map_d[0] = '0;
    rdy_d[0] = 1'b1;
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int e = 0; e < NMAP; e++) begin
        map_q[e] <= PR'(e);
      end
      rdy_q <= '1;
    end else begin
      map_q <= map_d;
      rdy_q <= rdy_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_map_table.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_map_table : directed self-checking bench for map_table
// | Revision     : 1.0 - initial release
// +----------------------------------------------------------------------------
module tb_map_table;

  logic             clock;
  logic             reset_n;
  logic [2:0]       en;
  logic [2:0][4:0]  dest, s1, s2;
  logic [2:0][5:0]  free, cdbt;
  logic [2:0]       cdbv;
  logic             rec;
  logic [31:0][5:0] amap;
  logic [2:0][5:0]  s1p, s2p, told;
  logic [2:0]       s1r, s2r;

  int n_checks = 0;
  int n_fail   = 0;

  map_table #(.PR(6), .AR(5)) dut (
    .clock_i      (clock),
    .reset_i      (reset_n),
    .DispatchEN_i (en),
    .dest_arch_i  (dest),
    .src1_arch_i  (s1),
    .src2_arch_i  (s2),
    .FreeReg_i    (free),
    .CDB_valid_i  (cdbv),
    .CDB_tag_i    (cdbt),
    .BPRecoverEN_i(rec),
    .arch_map_i   (amap),
    .src1_preg_o  (s1p),
    .src1_ready_o (s1r),
    .src2_preg_o  (s2p),
    .src2_ready_o (s2r),
    .told_preg_o  (told)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic quiet();
    en   = '0;
    cdbv = '0;
    rec  = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    en = '0; dest = '0; s1 = '0; s2 = '0; free = '0; cdbv = '0; cdbt = '0; rec = 1'b0;
    for (int i = 0; i < 32; i++) amap[i] = 6'(i + 1);
    amap[0] = 6'd5;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Reset state lookup
    s1 = {5'd3, 5'd7, 5'd31};
    dest[0] = 5'd5;
    #1;
    chk("rst_src1_s2", s1p[2], 3);
    chk("rst_src1_s1", s1p[1], 7);
    chk("rst_src1_s0", s1p[0], 31);
    chk("rst_src1_rdy", s1r, 3'b111);
    chk("rst_told_d5", told[0], 5);

    // Single rename: slot2 dest 4 -> 32
    @(negedge clock);
    en = 3'b100; dest[2] = 5'd4; free[2] = 6'd32;
    #1;
    chk("ren_told", told[2], 4);
    @(negedge clock);
    quiet(); s1[2] = 5'd4;
    #1;
    chk("ren_preg", s1p[2], 32);
    chk("ren_rdy", s1r[2], 0);

    // Intra-group chain on arch reg 1
    @(negedge clock);
    en = 3'b110;
    dest = {5'd1, 5'd1, 5'd1}; free = {6'd40, 6'd41, 6'd42};
    s1 = {5'd0, 5'd1, 5'd1}; s2 = {5'd0, 5'd0, 5'd1};
    #1;
    chk("chain_s1_src1", s1p[1], 40);
    chk("chain_s1_rdy", s1r[1], 0);
    chk("chain_told2", told[2], 1);
    chk("chain_told1", told[1], 40);
    chk("chain_s0_src1", s1p[0], 41);
    chk("chain_s0_src2", s2p[0], 41);
    chk("chain_s0_rdy", {s1r[0], s2r[0]}, 2'b00);
    chk("chain_told0", told[0], 41);
    @(negedge clock);
    quiet(); s1[2] = 5'd1;
    #1;
    chk("chain_map1", s1p[2], 41);

    // CDB wake-up of map[6]=45
    en = 3'b100; dest[2] = 5'd6; free[2] = 6'd45;
    @(negedge clock);
    quiet(); s2[0] = 5'd6;
    #1;
    chk("cdb_pre_preg", s2p[0], 45);
    chk("cdb_pre_rdy", s2r[0], 0);
    cdbv = 3'b010; cdbt[1] = 6'd45;
    #1;
    chk("cdb_byp_rdy", s2r[0], 1);
    @(negedge clock);
    quiet();
    #1;
    chk("cdb_stored_rdy", s2r[0], 1);

    // Rename overrides same-cycle CDB set; CDB on another entry still sets
    en = 3'b010; dest[1] = 5'd6; free[1] = 6'd46;
    @(negedge clock);
    quiet();
    en = 3'b100; dest[2] = 5'd6; free[2] = 6'd50;
    cdbv = 3'b101; cdbt[0] = 6'd46; cdbt[2] = 6'd32;
    @(negedge clock);
    quiet(); s1[0] = 5'd6; s1[1] = 5'd4;
    #1;
    chk("cdbren_preg", s1p[0], 50);
    chk("cdbren_rdy", s1r[0], 0);
    chk("cdb_map4_preg", s1p[1], 32);
    chk("cdb_map4_rdy", s1r[1], 1);

    // Intra-group hit suppresses CDB readiness
    en = 3'b100; dest[2] = 5'd7; free[2] = 6'd51; s1[0] = 5'd7;
    cdbv = 3'b001; cdbt[0] = 6'd51;
    #1;
    chk("grp_cdb_preg", s1p[0], 51);
    chk("grp_cdb_rdy", s1r[0], 0);

    // x0 destination and source
    @(negedge clock);
    quiet();
    en = 3'b110; dest = {5'd0, 5'd0, 5'd0}; free = {6'd34, 6'd33, 6'd0};
    s1[1] = 5'd0;
    #1;
    chk("x0_told2", told[2], 34);
    chk("x0_told1", told[1], 33);
    chk("x0_src_preg", s1p[1], 0);
    chk("x0_src_rdy", s1r[1], 1);

    // Duplicate dest in one group: youngest wins
    @(negedge clock);
    quiet();
    en = 3'b101; dest = {5'd9, 5'd0, 5'd9}; free = {6'd52, 6'd0, 6'd53};
    #1;
    chk("dup_told0", told[0], 52);
    @(negedge clock);
    quiet(); s1 = {5'd9, 5'd0, 5'd0};
    #1;
    chk("dup_map9", s1p[2], 53);
    chk("dup_rdy9", s1r[2], 0);

    // Recovery with dispatch and CDB asserted: both are dropped
    rec = 1'b1; en = 3'b111;
    dest = {5'd10, 5'd11, 5'd12}; free = {6'd55, 6'd56, 6'd57};
    cdbv = 3'b111; cdbt = {6'd53, 6'd50, 6'd41};
    @(negedge clock);
    quiet();
    s1 = {5'd1, 5'd9, 5'd31}; s2 = {5'd0, 5'd6, 5'd4};
    #1;
    chk("rec_map1", s1p[2], 2);
    chk("rec_map9", s1p[1], 10);
    chk("rec_map31", s1p[0], 32);
    chk("rec_map6", s2p[1], 7);
    chk("rec_map4", s2p[0], 5);
    chk("rec_rdy", {s1r, s2r}, 6'b111111);
    chk("rec_told10", told[2], 11);
    chk("rec_told11", told[1], 12);
    chk("rec_told12", told[0], 13);

    // Asynchronous reset mid-cycle
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_map1", s1p[2], 1);
    chk("arst_map9", s1p[1], 9);
    chk("arst_map6", s2p[1], 6);
    chk("arst_told12", told[0], 12);
    chk("arst_rdy", {s1r, s2r}, 6'b111111);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
